// File: rtl/pipelined_color_mapper.sv
// Maps per-pixel sim state (ant/sugar/nest flags plus NUM_CH pheromone signals) to 24-bit VGA RGB.
// Latency: fixed 3 cycles (S1 register, S2 intensity, S3 blend/overlay), 1 pixel per cycle.
// Backpressure: all stages advance only when out_ready=1, otherwise everything holds; in_ready = out_ready.
// Optional: define CMAP_ANT_BLINK_EN to make sugar-carrying ants blink on frame_cnt[BLINK_BIT].
module pipelined_color_mapper #(
  parameter int                   NUM_CH      = 2,
  parameter int                   SIG_W       = 16,
  parameter int                   DISP_MIN    = 8,
  parameter int                   SCALE_SHIFT = 1,
  parameter logic [NUM_CH*24-1:0] CH_TINT     = {24'h0000FF, 24'hFF0000},
  parameter logic [23:0]          BASE_RGB    = 24'h669900,
  parameter int                   BLINK_BIT   = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    render_ant,
  input  logic                    ant_carrying,
  input  logic                    render_sugar,
  input  logic                    render_nest,
  input  logic [NUM_CH*SIG_W-1:0] render_signal,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic [7:0]              frame_cnt
);

  localparam logic [SIG_W-1:0] DMIN = SIG_W'(DISP_MIN);
  localparam logic [SIG_W-1:0] ISAT = SIG_W'(255);

  logic adv;
  assign adv      = out_ready;
  assign in_ready = out_ready;

  // S1: capture flags and raw channel signals
  logic                    s1_vld, s1_ant, s1_carry, s1_sugar, s1_nest;
  logic [NUM_CH*SIG_W-1:0] s1_sig;

  // Stage 1 register: sample the pixel inputs whenever the pipe advances
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_vld   <= 1'b0;
      s1_ant   <= 1'b0;
      s1_carry <= 1'b0;
      s1_sugar <= 1'b0;
      s1_nest  <= 1'b0;
      s1_sig   <= '0;
    end else if (adv) begin
      s1_vld   <= in_valid;
      s1_ant   <= render_ant;
      s1_carry <= ant_carrying;
      s1_sugar <= render_sugar;
      s1_nest  <= render_nest;
      s1_sig   <= render_signal;
    end
  end

  // Per-channel intensity: zero at or below the display floor, then scaled and clipped to 8 bits
  logic [NUM_CH*8-1:0] s1_int;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_int
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] d;
    assign sig = s1_sig[c*SIG_W +: SIG_W];
    assign d   = (sig - DMIN) >> SCALE_SHIFT;
    assign s1_int[c*8 +: 8] = (sig <= DMIN) ? 8'd0 : ((d > ISAT) ? 8'hFF : d[7:0]);
  end

  // S2: intensities plus flags carried along
  logic                s2_vld, s2_ant, s2_carry, s2_sugar, s2_nest;
  logic [NUM_CH*8-1:0] s2_int;

  // Stage 2 register: hold computed intensities for the blend stage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s2_vld   <= 1'b0;
      s2_ant   <= 1'b0;
      s2_carry <= 1'b0;
      s2_sugar <= 1'b0;
      s2_nest  <= 1'b0;
      s2_int   <= '0;
    end else if (adv) begin
      s2_vld   <= s1_vld;
      s2_ant   <= s1_ant;
      s2_carry <= s1_carry;
      s2_sugar <= s1_sugar;
      s2_nest  <= s1_nest;
      s2_int   <= s1_int;
    end
  end

  // Blend: base colour plus each channel's tint scaled by its intensity, saturating per component
  logic [23:0] blend_rgb;
  logic [10:0] acc;
  logic [15:0] prod;
  always_comb begin
    blend_rgb = '0;
    acc       = '0;
    prod      = '0;
    for (int k = 0; k < 3; k++) begin
      acc = {3'b000, BASE_RGB[k*8 +: 8]};
      for (int c = 0; c < NUM_CH; c++) begin
        prod = 16'(s2_int[c*8 +: 8]) * 16'(CH_TINT[c*24 + k*8 +: 8]);
        acc  = acc + 11'(prod >> 8);
      end
      blend_rgb[k*8 +: 8] = (acc > 11'd255) ? 8'hFF : acc[7:0];
    end
  end

  // Ant colour; with blinking enabled a carrying ant follows the frame counter phase
  logic [23:0] ant_rgb;
`ifdef CMAP_ANT_BLINK_EN
  assign ant_rgb = (s2_carry && frame_cnt[BLINK_BIT]) ? 24'hFFFFFF : 24'h000000;
`else
  logic unused_blink;
  assign unused_blink = s2_carry ^ frame_cnt[BLINK_BIT];
  assign ant_rgb      = 24'h000000;
`endif

  // Overlay priority: ant, then sugar, then nest, then the blended signal colour
  logic [23:0] pix_rgb;
  always_comb begin
    pix_rgb = blend_rgb;
    if (s2_ant)        pix_rgb = ant_rgb;
    else if (s2_sugar) pix_rgb = 24'hFFFFFF;
    else if (s2_nest)  pix_rgb = 24'h8B4513;
  end

  // Stage 3 / output register: colour and valid held while downstream stalls
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      VGA_R     <= 8'd0;
      VGA_G     <= 8'd0;
      VGA_B     <= 8'd0;
    end else if (adv) begin
      out_valid <= s2_vld;
      VGA_R     <= pix_rgb[23:16];
      VGA_G     <= pix_rgb[15:8];
      VGA_B     <= pix_rgb[7:0];
    end
  end

  // Frame counter: free-running on frame_start pulses, ignores backpressure, wraps naturally
  always_ff @(posedge Clk) begin
    if (Reset)            frame_cnt <= 8'd0;
    else if (frame_start) frame_cnt <= frame_cnt + 8'd1;
  end

endmodule

// File: tb/tb_pipelined_color_mapper.sv
// Self-checking bench for pipelined_color_mapper: directed vector table, stall/reset
// sequences, frame counter and randomized stream against a behavioural colour model.
module tb_pipelined_color_mapper;

`ifdef CMAP_ANT_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, frame_start, in_valid, in_ready;
  logic        render_ant, ant_carrying, render_sugar, render_nest;
  logic [31:0] render_signal;
  logic        out_ready, out_valid;
  logic [7:0]  VGA_R, VGA_G, VGA_B, frame_cnt;

  always #5 Clk = ~Clk;

  pipelined_color_mapper dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready),
    .render_ant(render_ant), .ant_carrying(ant_carrying),
    .render_sugar(render_sugar), .render_nest(render_nest),
    .render_signal(render_signal), .out_ready(out_ready), .out_valid(out_valid),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic        ant, carry, sugar, nest;
    logic [15:0] s0, s1;
    logic [23:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  fc_model = 8'd0;
  logic        held_vld = 1'b0;
  logic [24:0] held_val = '0;
  int          n_out    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Reference colour from the rules: overlays first, then base + tinted intensities.
  function automatic logic [23:0] model_rgb(input vec_t p, input logic [7:0] fc);
    int sig[2];
    int inten[2];
    int tint[2][3];
    int base[3];
    int sum[3];
    if (p.ant)   return (BLINK_ON && p.carry && fc[4]) ? 24'hFFFFFF : 24'h000000;
    if (p.sugar) return 24'hFFFFFF;
    if (p.nest)  return 24'h8B4513;
    sig[0] = int'(p.s0);
    sig[1] = int'(p.s1);
    tint = '{'{255, 0, 0}, '{0, 0, 255}};   // ch0 red, ch1 blue ({R,G,B})
    base = '{102, 153, 0};
    for (int c = 0; c < 2; c++) begin
      if (sig[c] <= 8) inten[c] = 0;
      else inten[c] = ((sig[c] - 8) / 2 > 255) ? 255 : (sig[c] - 8) / 2;
    end
    for (int k = 0; k < 3; k++) begin
      sum[k] = base[k];
      for (int c = 0; c < 2; c++) sum[k] += (inten[c] * tint[c][k]) / 256;
      if (sum[k] > 255) sum[k] = 255;
    end
    return {sum[0][7:0], sum[1][7:0], sum[2][7:0]};
  endfunction

  function automatic vec_t mk(input logic a, input logic cr, input logic s, input logic n,
                              input logic [15:0] x, input logic [15:0] y, input logic [23:0] e);
    vec_t v;
    v.ant = a; v.carry = cr; v.sugar = s; v.nest = n; v.s0 = x; v.s1 = y; v.exp = e;
    return v;
  endfunction

  task automatic set_pix(input vec_t p);
    render_ant    = p.ant;
    ant_carrying  = p.carry;
    render_sugar  = p.sugar;
    render_nest   = p.nest;
    render_signal = {p.s1, p.s0};
  endtask

  // One isolated pixel into an empty pipe: checks exact 3-cycle latency and single output.
  task automatic send_one(input string nm, input vec_t v);
    set_pix(v);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({nm, "_early"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_rgb"}, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, v.exp});
    step();
    chk({nm, "_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  // One streaming cycle with scoreboard: consume, stall-hold check, accept.
  task automatic drive(input vec_t p, input logic vld, input logic rdy);
    set_pix(p);
    in_valid = vld; out_ready = rdy; frame_start = 1'b0;
    #1;
    if (held_vld) chk("stall_hold", {7'd0, out_valid, VGA_R, VGA_G, VGA_B}, {7'd0, held_val});
    held_vld = !rdy;
    held_val = {out_valid, VGA_R, VGA_G, VGA_B};
    if (out_valid && rdy) begin
      n_out++;
      if (exp_q.size() == 0) chk("extra_output", {8'd0, VGA_R, VGA_G, VGA_B}, 32'hFFFF_FFFF);
      else chk("stream_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_q.pop_front()});
    end
    if (vld && in_ready) exp_q.push_back(model_rgb(p, fc_model));
    @(posedge Clk);
    #0.5;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      step();
      fc_model = fc_model + 8'd1;
    end
    frame_start = 1'b0;
  endtask

  function automatic vec_t rand_pix();
    vec_t p;
    p.ant   = ($urandom_range(0, 9) == 0);
    p.carry = $urandom_range(0, 1) == 1;
    p.sugar = ($urandom_range(0, 9) == 0);
    p.nest  = ($urandom_range(0, 9) == 0);
    p.s0    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 600));
    p.s1    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 600));
    p.exp   = '0;
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    vec_t idle;
    vec_t sp[5];
    int   k;
    int   cyc;

    vt[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd0,     24'h669900);
    vt[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd264,   24'h66997F);
    vt[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd1000,  24'h6699FE);
    vt[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd264,   16'd0,     24'hE59900);
    vt[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd1000,  16'd1000,  24'hFF99FE);
    vt[5]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'd1000,  16'd0,     24'h000000);
    vt[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 16'd1000,  16'd0,     24'hFFFFFF);
    vt[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'd1000,  16'd1000,  24'h8B4513);
    vt[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd8,     16'd8,     24'h669900);
    vt[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd12,    24'h669901);
    vt[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd517,   24'h6699FD);
    vt[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd65535, 16'd65535, 24'hFF99FE);
    idle   = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd0,     24'h0);

    // Reset, with a frame_start pulse that must be ignored
    Reset = 1'b1; frame_start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_pix(idle);
    step();
    step();
    frame_start = 1'b0;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    chk("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    Reset = 1'b0;
    fc_model = 8'd0;
    out_ready = 1'b0; #1;
    chk("in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; #1;
    chk("in_ready_high", {31'd0, in_ready}, 32'd1);
    step();

    // Directed vector table
    for (int i = 0; i < 12; i++) send_one($sformatf("vec%0d", i), vt[i]);

    // Five back-to-back pixels with a two-cycle downstream stall mid-stream
    for (int i = 0; i < 5; i++)
      sp[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'(20 + 50 * i), 16'(300 + 60 * i), 24'h0);
    exp_q.delete(); held_vld = 1'b0; n_out = 0;
    k = 0; cyc = 0;
    while (k < 5 && cyc < 20) begin
      if (cyc == 3 || cyc == 4) drive(sp[k], 1'b1, 1'b0);
      else begin
        drive(sp[k], 1'b1, 1'b1);
        k++;
      end
      cyc++;
    end
    for (int i = 0; i < 6; i++) drive(idle, 1'b0, 1'b1);
    chk("stall_stream_count", n_out, 32'd5);
    chk("stall_stream_drained", exp_q.size(), 32'd0);

    // Randomized stream with random backpressure
    exp_q.delete(); held_vld = 1'b0;
    for (int i = 0; i < 400; i++)
      drive(rand_pix(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8));
    for (int i = 0; i < 6; i++) drive(idle, 1'b0, 1'b1);
    chk("random_drained", exp_q.size(), 32'd0);
    #4;

    // Reset mid-stream drops in-flight pixels and clears the frame counter
    pulse(3);
    chk("frame_cnt_3", {24'd0, frame_cnt}, {24'd0, fc_model});
    exp_q.delete(); held_vld = 1'b0;
    for (int i = 0; i < 3; i++) drive(vt[4], 1'b1, 1'b1);
    #4;
    Reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    chk("midreset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    Reset = 1'b0; in_valid = 1'b0; fc_model = 8'd0; exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_empty", {31'd0, out_valid}, 32'd0);
    end
    send_one("post_reset_first", vt[1]);

    // Frame counter and carrying-ant rendering
    send_one("carry_fc0", mk(1'b1, 1'b1, 1'b0, 1'b0, 16'd1000, 16'd0, 24'h000000));
    pulse(15);
    chk("frame_cnt_15", {24'd0, frame_cnt}, 32'd15);
    send_one("carry_fc15", mk(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 24'h000000));
    pulse(1);
    chk("frame_cnt_16", {24'd0, frame_cnt}, 32'd16);
    send_one("carry_fc16", mk(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0,
                              BLINK_ON ? 24'hFFFFFF : 24'h000000));
    send_one("nocarry_fc16", mk(1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 24'h000000));
    out_ready = 1'b0;
    pulse(240);
    chk("frame_cnt_wrap", {24'd0, frame_cnt}, 32'd0);
    pulse(1);
    chk("frame_cnt_1", {24'd0, frame_cnt}, 32'd1);
    out_ready = 1'b1;
    Reset = 1'b1; frame_start = 1'b1;
    step();
    Reset = 1'b0; frame_start = 1'b0;
    chk("frame_start_in_reset", {24'd0, frame_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
